// File: rtl/cell_test_seq_if.sv
// Start/status and cell-pin bundle between the cell test sequencer and its environment.
// The environment owns start/abort/mode and the cell output; the sequencer owns the rest.
interface cell_test_seq_if;
    localparam int unsigned CNT_W = 8;

    logic             start;
    logic             abort;
    logic             mode;
    logic             dut_a;
    logic             dut_z;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] vec_idx;

    modport master (
        output start, abort, mode, dut_z,
        input  dut_a, busy, done, pass, err_count, vec_idx
    );

    modport slave (
        input  start, abort, mode, dut_z,
        output dut_a, busy, done, pass, err_count, vec_idx
    );
endinterface

// File: rtl/cell_test_seq.sv
// On-chip sequencer that drives an inverter cell with toggle or LFSR vectors,
// waits a settle interval, samples the output and accumulates mismatches.
module cell_test_seq #(
    parameter int unsigned N_VEC     = 4,
    parameter int unsigned SETTLE    = 2,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic            clk,
    input  logic            rst_n,
    cell_test_seq_if.slave  bus
);
    localparam int unsigned VEC_W  = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LFSR_W = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_WAIT   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [VEC_W-1:0]    err_q, err_d;
    logic                dut_a_q, dut_a_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                lfsr_fb_c;

    // Fibonacci feedback for x^8+x^6+x^5+x^4+1, shifting right into bit 7
    assign lfsr_fb_c = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            dut_a_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            dut_a_q <= dut_a_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        err_d   = err_q;
        dut_a_d = dut_a_q;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    mode_d  = bus.mode;
                    err_d   = '0;
                    vec_d   = '0;
                    pass_d  = 1'b0;
                    lfsr_d  = LFSR_SEED;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                dut_a_d = mode_q ? lfsr_q[0] : vec_q[0];
                cnt_d   = CNT_W'(SETTLE - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                // An inverter output equal to its input is a mismatch
                if (bus.dut_z == dut_a_q) begin
                    err_d = err_q + VEC_W'(1);
                end
                if (vec_q == VEC_W'(N_VEC - 1)) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + VEC_W'(1);
                    state_d = S_DRIVE;
                    if (mode_q) begin
                        lfsr_d = {lfsr_fb_c, lfsr_q[LFSR_W-1:1]};
                    end
                end
            end
            S_DONE: begin
                pass_d  = (err_q == '0);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Cancel overrides any in-flight update; counters keep their progress
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            pass_d  = 1'b0;
            dut_a_d = 1'b0;
            err_d   = err_q;
            vec_d   = vec_q;
            lfsr_d  = lfsr_q;
            cnt_d   = cnt_q;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign bus.dut_a     = dut_a_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.vec_idx   = vec_q;
endmodule

// File: tb/tb_cell_test_seq.sv
// Self-checking bench for cell_test_seq: two instances (4 vectors/settle 2 and
// 8 vectors/settle 1) driven with directed and randomized cell fault patterns.
module tb_cell_test_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    int          kind_a = 0;
    int          kind_b = 0;
    logic [7:0]  mask_a = '0;
    logic [7:0]  mask_b = '0;

    always #5 clk = ~clk;

    cell_test_seq_if ifa ();
    cell_test_seq_if ifb ();

    cell_test_seq #(.N_VEC(4), .SETTLE(2), .LFSR_SEED(8'hA5)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    cell_test_seq #(.N_VEC(8), .SETTLE(1), .LFSR_SEED(8'hA5)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    // Cell under test: 0 = ideal inverter, 1 = stuck-at-0, 2 = buffer; flip injects a per-vector fault
    function automatic logic cell_f(input int kind, input logic a, input logic flip);
        logic z;
        case (kind)
            0:       z = ~a;
            1:       z = 1'b0;
            default: z = a;
        endcase
        return z ^ flip;
    endfunction

    always_comb ifa.dut_z = cell_f(kind_a, ifa.dut_a, mask_a[ifa.vec_idx[2:0]]);
    always_comb ifb.dut_z = cell_f(kind_b, ifb.dut_a, mask_b[ifb.vec_idx[2:0]]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {dut_a, busy, done, pass, err_count, vec_idx}
    function automatic logic [19:0] snap(input int sel);
        if (sel != 0)
            return {ifb.dut_a, ifb.busy, ifb.done, ifb.pass, ifb.err_count, ifb.vec_idx};
        return {ifa.dut_a, ifa.busy, ifa.done, ifa.pass, ifa.err_count, ifa.vec_idx};
    endfunction

    task automatic drv(input int sel, input logic st, input logic ab, input logic md);
        if (sel != 0) begin
            ifb.start = st; ifb.abort = ab; ifb.mode = md;
        end else begin
            ifa.start = st; ifa.abort = ab; ifa.mode = md;
        end
    endtask

    // Full run: start in cycle 0, observe cycles 1..done+1 against the reference model
    task automatic run_vec(input int sel, input logic m, input int kind, input logic [7:0] mask,
                           input bit poke_start, input string tag);
        int          n, p, done_cyc, first_done, ndone, busy_bad, exp_err;
        logic [7:0]  lfsr, exp_a, obs_a;
        logic [19:0] s;
        n = (sel != 0) ? 8 : 4;
        p = (sel != 0) ? 3 : 4;
        done_cyc = n * p + 1;
        lfsr = 8'hA5;
        exp_a = '0;
        exp_err = 0;
        for (int i = 0; i < n; i++) begin
            exp_a[i] = m ? lfsr[0] : logic'(i % 2);
            if (cell_f(kind, exp_a[i], mask[i]) === exp_a[i]) exp_err++;
            lfsr = {^(lfsr & 8'h1D), lfsr[7:1]};
        end
        if (sel != 0) begin kind_b = kind; mask_b = mask; end
        else begin kind_a = kind; mask_a = mask; end
        first_done = -1; ndone = 0; busy_bad = 0; obs_a = '0;
        @(negedge clk);
        drv(sel, 1'b1, 1'b0, m);
        for (int c = 1; c <= done_cyc + 1; c++) begin
            @(negedge clk);
            s = snap(sel);
            if (c == 1) drv(sel, 1'b0, 1'b0, ~m);
            if (poke_start && c == 5) drv(sel, 1'b1, 1'b0, ~m);
            if (poke_start && c == 6) drv(sel, 1'b0, 1'b0, ~m);
            if (s[18] !== ((c <= done_cyc) ? 1'b1 : 1'b0)) busy_bad++;
            if (s[17] === 1'b1) begin
                ndone++;
                if (first_done < 0) first_done = c;
            end
            if (c % p == 0 && c / p >= 1 && c / p <= n) obs_a[c / p - 1] = s[19];
            if (c == done_cyc + 1) begin
                chk({tag, ".err"}, 32'(s[15:8]), 32'(exp_err));
                chk({tag, ".pass"}, 32'(s[16]), 32'(exp_err == 0));
            end
        end
        chk({tag, ".done_cyc"}, 32'(first_done), 32'(done_cyc));
        chk({tag, ".done_cnt"}, 32'(ndone), 32'd1);
        chk({tag, ".busy"}, 32'(busy_bad), 32'd0);
        chk({tag, ".dut_a"}, 32'(obs_a), 32'(exp_a));
    endtask

    initial begin
        logic [19:0] s;
        int          seen_done;
        rst_n = 1'b0;
        drv(0, 1'b0, 1'b0, 1'b0);
        drv(1, 1'b0, 1'b0, 1'b0);
        #12;
        chk("reset.a", 32'(snap(0)), 32'd0);
        chk("reset.b", 32'(snap(1)), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_vec(0, 1'b0, 0, 8'h00, 1'b1, "ideal_toggle");
        repeat (3) @(negedge clk);
        chk("no_second_run.busy", 32'(ifa.busy), 32'd0);
        run_vec(0, 1'b0, 1, 8'h00, 1'b0, "stuck0_toggle");
        run_vec(1, 1'b1, 2, 8'h00, 1'b0, "buffer_lfsr");

        for (int r = 0; r < 4; r++)
            run_vec(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 8'($urandom), 1'b0, "rand_a");
        for (int r = 0; r < 3; r++)
            run_vec(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 8'($urandom), 1'b0, "rand_b");

        // Abort in WAIT of vector 2 (cycles 10-11)
        kind_a = 0; mask_a = '0; seen_done = 0;
        @(negedge clk);
        drv(0, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (ifa.done === 1'b1) seen_done++;
            if (c == 1) drv(0, 1'b0, 1'b0, 1'b0);
            if (c == 10) drv(0, 1'b0, 1'b1, 1'b0);
        end
        drv(0, 1'b0, 1'b0, 1'b0);
        s = snap(0);
        chk("abort.state", 32'(s), {12'd0, 20'h00002});
        chk("abort.no_done", 32'(seen_done), 32'd0);
        run_vec(0, 1'b0, 0, 8'h00, 1'b0, "after_abort");

        // start and abort together in IDLE
        @(negedge clk);
        drv(0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        drv(0, 1'b0, 1'b0, 1'b0);
        chk("start_abort.busy", 32'(ifa.busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("start_abort.idle", 32'(ifa.busy), 32'd0);

        // Reset during WAIT of vector 3 (cycle 14)
        @(negedge clk);
        drv(0, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) drv(0, 1'b0, 1'b0, 1'b0);
        end
        chk("pre_reset.busy", 32'(ifa.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'(snap(0)), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset.idle", 32'(snap(0)), 32'd0);
        run_vec(0, 1'b1, 0, 8'h00, 1'b0, "post_reset_lfsr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
